multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath enables per state.
- Handshakes with instruction/data memory via mem_ready and supports a wait timeout.
- Adds a sticky fault report and a retired-instruction counter; sits between the instruction register and the datapath muxes/ALU.

---
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables for the current state. It waits on mem_ready in FETCH and
// MEM, with an optional timeout. It also keeps a sticky fault report and a
// count of retired instructions.
module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [2:0]          state,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic                fault,
  output logic [1:0]          fault_code
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  // The counter only has to reach MAX_WAIT-1; the last waiting cycle is the
  // one where wait_q == MAX_WAIT-1.
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic [1:0]          fcode_q, fcode_d;
  logic                wait_expired;

  // Opcodes are compared zero-extended, so wider opcode fields only decode
  // the listed low values.
  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    case (32'(op))
      32'h0, 32'h1, 32'h2, 32'h3, 32'h6,
      32'h7, 32'h8, 32'hA, 32'hE, 32'hF: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] op_alu(input logic [OPCODE_W-1:0] op);
    case (32'(op))
      32'h0:                      op_alu = ALUOP_W'(3'b000);
      32'h1:                      op_alu = ALUOP_W'(3'b001);
      32'h6, 32'hE:               op_alu = ALUOP_W'(3'b100);
      32'h7:                      op_alu = ALUOP_W'(3'b101);
      default:                    op_alu = ALUOP_W'(3'b011);
    endcase
  endfunction

  // Immediate B operand for ADDI and the address calculation of LW/SW.
  function automatic logic op_imm(input logic [OPCODE_W-1:0] op);
    op_imm = (32'(op) == 32'h3) || (32'(op) == 32'h8) || (32'(op) == 32'hA);
  endfunction

  // The destination is rd for the three-register ALU forms only.
  function automatic logic op_rd(input logic [OPCODE_W-1:0] op);
    case (32'(op))
      32'h0, 32'h1, 32'h2, 32'h6, 32'h7: op_rd = 1'b1;
      default:                           op_rd = 1'b0;
    endcase
  endfunction

  assign wait_expired = (MAX_WAIT > 0) && (wait_q == WAIT_LAST);

  // State and bookkeeping registers; reset may land mid-instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      fcode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      fcode_q <= fcode_d;
    end
  end

  // Next-state logic and per-state datapath enables.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = '0;        // cleared on every transition into FETCH/MEM
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    fcode_d    = fcode_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = '0;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          fcode_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        // The instruction register is only valid from here on, so this
        // state decodes the live opcode and latches it for later states.
        op_d = opcode;
        if (!op_legal(opcode)) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          fcode_d = 2'b01;
        end else if (32'(opcode) == 32'hF) begin
          pc_write = 1'b1;
          jump     = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = op_alu(op_q);
        alu_src = op_imm(op_q);
        reg_dst = op_rd(op_q);
        if (32'(op_q) == 32'hE) begin
          // The datapath ANDs pc_write with its not-zero flag.
          branch   = 1'b1;
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if ((32'(op_q) == 32'h8) || (32'(op_q) == 32'hA)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op    = op_alu(op_q);
        alu_src   = op_imm(op_q);
        mem_read  = (32'(op_q) == 32'h8);
        mem_write = (32'(op_q) == 32'hA);
        if (mem_ready) begin
          if (32'(op_q) == 32'h8) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_expired) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          fcode_d = 2'b11;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        alu_op     = op_alu(op_q);
        alu_src    = op_imm(op_q);
        reg_dst    = op_rd(op_q);
        reg_write  = 1'b1;
        mem_to_reg = (32'(op_q) == 32'h8);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Hold every enable low for as long as reset is asserted.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      alu_op     = '0;
      retire     = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;
  assign fault       = fault_q;
  assign fault_code  = fcode_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. dut_a uses the default
// parameters; dut_b uses MAX_WAIT=0 and CNT_W=4.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  logic [3:0] opcode_a = '0, opcode_b = '0;
  logic ready_a = 1'b0, ready_b = 1'b0;

  logic pc_write_a, ir_write_a, mem_read_a, mem_write_a, reg_dst_a, alu_src_a;
  logic mem_to_reg_a, reg_write_a, branch_a, jump_a, retire_a, fault_a;
  logic [2:0] alu_op_a, state_a;
  logic [15:0] count_a;
  logic [1:0] fcode_a;

  logic pc_write_b, ir_write_b, mem_read_b, mem_write_b, reg_dst_b, alu_src_b;
  logic mem_to_reg_b, reg_write_b, branch_b, jump_b, retire_b, fault_b;
  logic [2:0] alu_op_b, state_b;
  logic [3:0] count_b;
  logic [1:0] fcode_b;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control dut_a (
    .clk(clk), .rst(rst), .opcode(opcode_a), .mem_ready(ready_a),
    .pc_write(pc_write_a), .ir_write(ir_write_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .reg_dst(reg_dst_a), .alu_src(alu_src_a),
    .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a), .branch(branch_a),
    .jump(jump_a), .alu_op(alu_op_a), .state(state_a), .retire(retire_a),
    .instr_count(count_a), .fault(fault_a), .fault_code(fcode_a)
  );

  multicycle_control #(.MAX_WAIT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode_b), .mem_ready(ready_b),
    .pc_write(pc_write_b), .ir_write(ir_write_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .reg_dst(reg_dst_b), .alu_src(alu_src_b),
    .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b), .branch(branch_b),
    .jump(jump_b), .alu_op(alu_op_b), .state(state_b), .retire(retire_b),
    .instr_count(count_b), .fault(fault_b), .fault_code(fcode_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Run one ALU instruction from FETCH with mem_ready high; ends in FETCH.
  task automatic run_alu(input logic [3:0] op, input logic [2:0] e_alu,
                         input logic e_src, input logic e_dst);
    opcode_a = op; ready_a = 1'b1; #1;
    check_val("alu_fetch_state", 32'(state_a), 0);
    check_val("alu_fetch_irw", 32'(ir_write_a), 1);
    tick(); #1;
    check_val("alu_decode_state", 32'(state_a), 1);
    tick(); #1;
    check_val("alu_exec_state", 32'(state_a), 2);
    check_val("alu_exec_ctl", {26'd0, alu_op_a, alu_src_a, reg_dst_a}, {26'd0, e_alu, e_src, e_dst});
    tick(); #1;
    check_val("alu_wb_state", 32'(state_a), 4);
    check_val("alu_wb_ctl", {25'd0, reg_write_a, retire_a, alu_op_a, reg_dst_a, mem_to_reg_a},
              {25'd0, 1'b1, 1'b1, e_alu, e_dst, 1'b0});
    exp_cnt = (exp_cnt + 1) % 65536;
    tick(); #1;
    check_val("alu_count", 32'(count_a), 32'(exp_cnt));
  endtask

  initial begin
    int n;
    int bad;
    int mem_cycles;

    // Reset: outputs stay low even while mem_ready is asserted.
    repeat (2) @(posedge clk);
    tick();
    ready_a = 1'b1; #1;
    check_val("rst_mem_read", 32'(mem_read_a), 0);
    check_val("rst_ir_write", 32'(ir_write_a), 0);
    check_val("rst_state", 32'(state_a), 0);
    rst = 1'b0; #1;
    check_val("rel_mem_read", 32'(mem_read_a), 1);

    // ALU group: opcode, alu_op, alu_src, reg_dst.
    run_alu(4'h2, 3'b011, 1'b0, 1'b1);
    run_alu(4'h3, 3'b011, 1'b1, 1'b0);
    run_alu(4'h6, 3'b100, 1'b0, 1'b1);
    run_alu(4'h0, 3'b000, 1'b0, 1'b1);
    run_alu(4'h1, 3'b001, 1'b0, 1'b1);
    run_alu(4'h7, 3'b101, 1'b0, 1'b1);

    // LW with mem_ready low for 3 MEM cycles.
    opcode_a = 4'h8; ready_a = 1'b1;
    tick(); tick(); #1;
    check_val("lw_exec_ctl", {29'd0, alu_op_a}, 32'd3);
    ready_a = 1'b0;
    mem_cycles = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) ready_a = 1'b1;
      #1;
      if (state_a == 3'd3 && mem_read_a) mem_cycles++;
      if (i == 3) begin
        tick();
        break;
      end
      tick();
    end
    check_val("lw_mem_cycles", 32'(mem_cycles), 4);
    #1;
    check_val("lw_wb_ctl", {28'd0, state_a, mem_to_reg_a}, {28'd0, 3'd4, 1'b1});
    check_val("lw_wb_regdst", {30'd0, reg_write_a, reg_dst_a}, {30'd0, 1'b1, 1'b0});
    exp_cnt++;
    tick(); #1;
    check_val("lw_count", 32'(count_a), 32'(exp_cnt));

    // SW with mem_ready high: retires in MEM after 4 cycles.
    opcode_a = 4'hA; ready_a = 1'b1;
    tick(); tick(); tick(); #1;
    check_val("sw_mem_ctl", {29'd0, state_a == 3'd3, mem_write_a, retire_a}, {29'd0, 3'b111});
    exp_cnt++;
    tick(); #1;
    check_val("sw_count", 32'(count_a), 32'(exp_cnt));

    // BNE: branch and pc_write in EXEC, 3 cycles.
    opcode_a = 4'hE;
    tick(); tick(); #1;
    check_val("bne_exec_ctl", {26'd0, alu_op_a, branch_a, pc_write_a, retire_a}, {26'd0, 3'b100, 3'b111});
    exp_cnt++;
    tick(); #1;
    check_val("bne_back_fetch", 32'(state_a), 0);
    check_val("bne_count", 32'(count_a), 32'(exp_cnt));

    // JMP: pc_write and jump in DECODE, 2 cycles.
    opcode_a = 4'hF;
    tick(); #1;
    check_val("jmp_dec_ctl", {29'd0, pc_write_a, jump_a, retire_a}, {29'd0, 3'b111});
    exp_cnt++;
    tick(); #1;
    check_val("jmp_count", 32'(count_a), 32'(exp_cnt));

    // SW interrupted by an asynchronous reset in MEM.
    opcode_a = 4'hA;
    tick(); tick(); ready_a = 1'b0;
    tick(); #1;
    check_val("swr_mem_write", 32'(mem_write_a), 1);
    rst = 1'b1; #1;
    check_val("swr_write_drop", 32'(mem_write_a), 0);
    rst = 1'b0; #1;
    check_val("swr_state", 32'(state_a), 0);
    check_val("swr_count", 32'(count_a), 0);

    // Illegal opcode 5: sticky FAULT with code 01.
    opcode_a = 4'h5; ready_a = 1'b1;
    tick(); tick(); #1;
    check_val("ill_state", 32'(state_a), 7);
    check_val("ill_fault", {29'd0, fault_a, fcode_a}, {29'd0, 3'b101});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ready_a = i[0];
      tick(); #1;
      if (pc_write_a || ir_write_a || mem_read_a || state_a != 3'd7 || fcode_a != 2'b01) bad++;
    end
    check_val("ill_hold", 32'(bad), 0);
    rst = 1'b1; #1;
    check_val("ill_rst_fault", 32'(fault_a), 0);
    rst = 1'b0;

    // mem_ready on the last allowed FETCH cycle completes normally.
    opcode_a = 4'hF; ready_a = 1'b0;
    repeat (15) tick();
    ready_a = 1'b1; #1;
    check_val("edge_fetch_irw", 32'(ir_write_a), 1);
    tick(); #1;
    check_val("edge_decode", {28'd0, state_a, fault_a}, {28'd0, 3'd1, 1'b0});
    tick();

    // FETCH timeout: exactly 16 FETCH cycles, then FAULT code 10.
    ready_a = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (state_a == 3'd0) n++;
      else break;
      tick();
    end
    check_val("tmo_fetch_cycles", 32'(n), 16);
    check_val("tmo_fault", {28'd0, state_a, fault_a}, {28'd0, 3'd7, 1'b1});
    check_val("tmo_code", 32'(fcode_a), 2);

    // MAX_WAIT=0: no timeout after 1000 cycles.
    tick();
    rst_b = 1'b0; ready_b = 1'b0; opcode_b = 4'hF;
    repeat (1000) tick();
    #1;
    check_val("nt_state", 32'(state_b), 0);
    check_val("nt_fault", 32'(fault_b), 0);

    // CNT_W=4: 17 JMPs, counter wraps 15 -> 0 -> 1.
    exp_cnt = 0;
    ready_b = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      #1;
      check_val("wr_fetch", 32'(state_b), 0);
      tick(); #1;
      check_val("wr_dec_jmp", {30'd0, pc_write_b, jump_b}, {30'd0, 2'b11});
      tick(); #1;
      exp_cnt = (exp_cnt + 1) % 16;
      check_val("wr_count", 32'(count_b), 32'(exp_cnt));
    end
    check_val("wr_final", 32'(count_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
